// File: rtl/arb_pkg.sv
// Shared types and constants for the eight-way request arbiter.
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int ID_W  = 3;
  localparam logic [ID_W-1:0] PTR_RST = 3'd7;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_e;

  // Rotate so that req[ptr] lands on the top bit and wins ties first.
  function automatic logic [N_REQ-1:0] rotate_req(input logic [N_REQ-1:0] r,
                                                  input logic [ID_W-1:0]  ptr);
    logic [2*N_REQ-1:0] dbl;
    dbl = {r, r} >> ({1'b0, ptr} + 4'd1);
    return dbl[N_REQ-1:0];
  endfunction
endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder; the highest set bit wins.
module prio_enc8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  output logic [ID_W-1:0]  idx,
  output logic             vld
);
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (vec[i]) begin
        idx = ID_W'(i);
        vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/req_arbiter_8.sv
// Eight-way grant/hold/gap arbiter with registered one-hot and encoded grant.
// Optional REQ_ARBITER_ROUND_ROBIN_EN rotates priority after every grant.
module req_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_vld,
  output logic             timeout
);
  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              timeout_d;

  logic [N_REQ-1:0]  rot_req;
  logic [ID_W-1:0]   enc_idx, winner;
  logic              enc_vld, hold_hit;

  assign rot_req  = rotate_req(req, ptr_q);
  assign winner   = enc_idx + ptr_q + 3'd1;
  assign hold_hit = (MAX_HOLD != 0) && (cnt_q == HOLD_W'(MAX_HOLD));

  prio_enc8 u_enc (
    .vec (rot_req),
    .idx (enc_idx),
    .vld (enc_vld)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && enc_vld) begin
          state_d = GRANT;
          owner_d = winner;
          cnt_d   = HOLD_W'(1);
`ifdef REQ_ARBITER_ROUND_ROBIN_EN
          ptr_d   = winner - 3'd1;
`else
          ptr_d   = PTR_RST;
`endif
        end
      end
      GRANT: begin
        // Release takes precedence over a coincident timeout.
        if (!req[owner_q]) begin
          state_d = GAP;
        end else if (hold_hit) begin
          state_d   = GAP;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + HOLD_W'(1);
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt     <= '0;
      gnt_id  <= '0;
      gnt_vld <= 1'b0;
      timeout <= 1'b0;
    end else begin
      gnt_vld <= (state_d == GRANT);
      gnt_id  <= (state_d == GRANT) ? owner_d : '0;
      gnt     <= (state_d == GRANT) ? (N_REQ'(1) << owner_d) : '0;
      timeout <= timeout_d;
    end
  end
endmodule
